// File: rtl/hwpe_stream_parity_fault_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_parity_fault_ctrl
// Description : Central fault controller for a bank of HWPE Stream parity
//               sinks. Arms checking after a warm-up window, masks channels,
//               keeps sticky per-channel flags and a saturating fault-cycle
//               counter, and raises a level IRQ at a programmable threshold.
//               Optional first-fault logging is enabled by defining
//               HWPE_STREAM_PARITY_FAULT_LOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_stream_parity_fault_ctrl #(
  parameter int unsigned  N_SINKS       = 4,
  parameter int unsigned  CNT_WIDTH     = 8,
  parameter int unsigned  WARMUP_CYCLES = 2,
  localparam int unsigned ID_W          = (N_SINKS > 1) ? $clog2(N_SINKS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [N_SINKS-1:0]   mask_i,
  input  logic [CNT_WIDTH-1:0] threshold_i,
  input  logic [N_SINKS-1:0]   fault_i,
  output logic [N_SINKS-1:0]   fault_sticky_o,
  output logic [CNT_WIDTH-1:0] fault_count_o,
`ifdef HWPE_STREAM_PARITY_FAULT_LOG_EN
  output logic [ID_W-1:0]      first_fault_id_o,
  output logic                 first_fault_valid_o,
`endif
  output logic                 irq_o,
  output logic [1:0]           state_o
);

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_WARMUP   = 2'd1;
  localparam logic [1:0] ST_ARMED    = 2'd2;
  localparam logic [1:0] ST_TRIPPED  = 2'd3;

  localparam int unsigned      WU_W    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WU_W-1:0]  WU_LOAD = WU_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]           state_q,  state_d;
  logic [WU_W-1:0]      wu_q,     wu_d;
  logic [N_SINKS-1:0]   sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] count_q,  count_d;

  logic [N_SINKS-1:0]   fault_vec;
  logic                 fault_cycle;

  // Qualify raw faults: only unmasked channels, only while checking is live.
  always_comb begin
    fault_vec   = fault_i & ~mask_i;
    fault_cycle = ((state_q == ST_ARMED) || (state_q == ST_TRIPPED)) && (|fault_vec);
  end

  // Sticky flags and saturating counter; a clear in the same cycle drops the fault.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (clear_i) begin
      sticky_d = '0;
      count_d  = '0;
    end else if (fault_cycle) begin
      sticky_d = sticky_q | fault_vec;
      count_d  = (count_q == CNT_MAX) ? count_q : count_q + CNT_WIDTH'(1);
    end
  end

  // Control FSM; dropping enable overrides every other transition.
  always_comb begin
    state_d = state_q;
    wu_d    = wu_q;
    case (state_q)
      ST_DISABLED: begin
        if (enable_i) begin
          if (WARMUP_CYCLES == 0) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_WARMUP;
            wu_d    = WU_LOAD;
          end
        end
      end
      ST_WARMUP: begin
        if (wu_q == '0) begin
          state_d = ST_ARMED;
        end else begin
          wu_d = wu_q - WU_W'(1);
        end
      end
      ST_ARMED: begin
        if (!clear_i && (threshold_i != '0) && (count_d >= threshold_i)) begin
          state_d = ST_TRIPPED;
        end
      end
      ST_TRIPPED: begin
        if (clear_i) begin
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_DISABLED;
    endcase
    if (!enable_i) begin
      state_d = ST_DISABLED;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_DISABLED;
      wu_q     <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wu_q     <= wu_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign fault_sticky_o = sticky_q;
  assign fault_count_o  = count_q;
  assign irq_o          = (state_q == ST_TRIPPED);
  assign state_o        = state_q;

`ifdef HWPE_STREAM_PARITY_FAULT_LOG_EN
  logic [ID_W-1:0] first_id;
  logic [ID_W-1:0] log_id_q,    log_id_d;
  logic            log_valid_q, log_valid_d;

  // Lowest-index unmasked faulting channel (descending scan, last hit wins).
  always_comb begin
    first_id = '0;
    for (int i = N_SINKS - 1; i >= 0; i--) begin
      if (fault_vec[i]) begin
        first_id = i[ID_W-1:0];
      end
    end
  end

  // Capture only the first faulty cycle since reset or the last clear.
  always_comb begin
    log_id_d    = log_id_q;
    log_valid_d = log_valid_q;
    if (clear_i) begin
      log_id_d    = '0;
      log_valid_d = 1'b0;
    end else if (fault_cycle && !log_valid_q) begin
      log_id_d    = first_id;
      log_valid_d = 1'b1;
    end
  end

  // First-fault log registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      log_id_q    <= '0;
      log_valid_q <= 1'b0;
    end else begin
      log_id_q    <= log_id_d;
      log_valid_q <= log_valid_d;
    end
  end

  assign first_fault_id_o    = log_id_q;
  assign first_fault_valid_o = log_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_parity_fault_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_stream_parity_fault_ctrl
// Description : Scoreboard bench for hwpe_stream_parity_fault_ctrl. Stimulus
//               pushes the expected post-edge snapshot for every cycle; a
//               monitor pops and compares one entry after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_stream_parity_fault_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [3:0] mask_i = '0;
  logic [7:0] threshold_i = '0;
  logic [3:0] fault_i = '0;
  logic [3:0] fault_sticky_o;
  logic [7:0] fault_count_o;
  logic       irq_o;
  logic [1:0] state_o;
  logic [1:0] first_fault_id_o;
  logic       first_fault_valid_o;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] st;
    logic [7:0] cnt;
    logic [3:0] sticky;
    logic       irq;
    logic       lv;
    logic [1:0] lid;
  } exp_t;

  exp_t sb[$];

  hwpe_stream_parity_fault_ctrl #(
    .N_SINKS(4), .CNT_WIDTH(8), .WARMUP_CYCLES(2)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .enable_i(enable_i),
    .clear_i(clear_i),
    .mask_i(mask_i),
    .threshold_i(threshold_i),
    .fault_i(fault_i),
    .fault_sticky_o(fault_sticky_o),
    .fault_count_o(fault_count_o),
`ifdef HWPE_STREAM_PARITY_FAULT_LOG_EN
    .first_fault_id_o(first_fault_id_o),
    .first_fault_valid_o(first_fault_valid_o),
`endif
    .irq_o(irq_o),
    .state_o(state_o)
  );

`ifndef HWPE_STREAM_PARITY_FAULT_LOG_EN
  assign first_fault_id_o    = '0;
  assign first_fault_valid_o = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] st, input logic [7:0] cnt, input logic [3:0] sticky,
                              input logic irq, input logic lv, input logic [1:0] lid);
    exp_t e;
    e.st = st; e.cnt = cnt; e.sticky = sticky; e.irq = irq; e.lv = lv; e.lid = lid;
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic cyc(input logic rst, input logic en, input logic clr, input logic [3:0] msk,
                     input logic [7:0] thr, input logic [3:0] f, input exp_t e);
    @(negedge clk_i);
    rst_ni      = rst;
    enable_i    = en;
    clear_i     = clr;
    mask_i      = msk;
    threshold_i = thr;
    fault_i     = f;
    sb.push_back(e);
  endtask

  // Monitor: compare one scoreboard entry shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("state",  32'(state_o),        32'(e.st));
        check("count",  32'(fault_count_o),  32'(e.cnt));
        check("sticky", 32'(fault_sticky_o), 32'(e.sticky));
        check("irq",    32'(irq_o),          32'(e.irq));
`ifdef HWPE_STREAM_PARITY_FAULT_LOG_EN
        check("log_valid", 32'(first_fault_valid_o), 32'(e.lv));
        check("log_id",    32'(first_fault_id_o),    32'(e.lid));
`endif
      end
    end
  end

  // Stimulus with hand-computed expectations.
  initial begin
    // Reset held
    cyc(0, 0, 0, 4'b0000, 8'd3, 4'b0000, mk(2'd0, 8'd0, 4'b0000, 0, 0, 2'd0));
    cyc(0, 0, 0, 4'b0000, 8'd3, 4'b0000, mk(2'd0, 8'd0, 4'b0000, 0, 0, 2'd0));
    // Warm-up: faults ignored
    cyc(1, 1, 0, 4'b0000, 8'd3, 4'b0001, mk(2'd1, 8'd0, 4'b0000, 0, 0, 2'd0));
    cyc(1, 1, 0, 4'b0000, 8'd3, 4'b0001, mk(2'd1, 8'd0, 4'b0000, 0, 0, 2'd0));
    cyc(1, 1, 0, 4'b0000, 8'd3, 4'b0001, mk(2'd2, 8'd0, 4'b0000, 0, 0, 2'd0));
    // Armed: three faulty cycles trip at threshold 3
    cyc(1, 1, 0, 4'b0000, 8'd3, 4'b0110, mk(2'd2, 8'd1, 4'b0110, 0, 1, 2'd1));
    cyc(1, 1, 0, 4'b0000, 8'd3, 4'b0110, mk(2'd2, 8'd2, 4'b0110, 0, 1, 2'd1));
    cyc(1, 1, 0, 4'b0000, 8'd3, 4'b0110, mk(2'd3, 8'd3, 4'b0110, 1, 1, 2'd1));
    // Masked faults change nothing
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 0, 4'b0100, 8'd3, 4'b0100, mk(2'd3, 8'd3, 4'b0110, 1, 1, 2'd1));
    // Clear beats a simultaneous fault; tripped -> armed
    cyc(1, 1, 1, 4'b0000, 8'd3, 4'b1000, mk(2'd2, 8'd0, 4'b0000, 0, 0, 2'd0));
    // Log lowest index of 4'b1010, later bit-3 fault does not overwrite
    cyc(1, 1, 0, 4'b0000, 8'd0, 4'b1010, mk(2'd2, 8'd1, 4'b1010, 0, 1, 2'd1));
    cyc(1, 1, 0, 4'b0000, 8'd0, 4'b1000, mk(2'd2, 8'd2, 4'b1010, 0, 1, 2'd1));
    // Threshold 0: count saturates at 255, never trips
    for (int k = 1; k <= 300; k++)
      cyc(1, 1, 0, 4'b0000, 8'd0, 4'b0001,
          mk(2'd2, ((k + 2) > 255) ? 8'd255 : 8'(k + 2), 4'b1011, 0, 1, 2'd1));
    cyc(1, 1, 1, 4'b0000, 8'd0, 4'b0000, mk(2'd2, 8'd0, 4'b0000, 0, 0, 2'd0));
    // Masking keeps an existing sticky bit
    cyc(1, 1, 0, 4'b0000, 8'd2, 4'b0010, mk(2'd2, 8'd1, 4'b0010, 0, 1, 2'd1));
    cyc(1, 1, 0, 4'b0010, 8'd2, 4'b0010, mk(2'd2, 8'd1, 4'b0010, 0, 1, 2'd1));
    cyc(1, 1, 0, 4'b0000, 8'd2, 4'b1100, mk(2'd3, 8'd2, 4'b1110, 1, 1, 2'd1));
    // Disable drops irq but keeps sticky/count; clear while disabled
    cyc(1, 0, 0, 4'b0000, 8'd2, 4'b0000, mk(2'd0, 8'd2, 4'b1110, 0, 1, 2'd1));
    cyc(1, 0, 1, 4'b0000, 8'd2, 4'b0000, mk(2'd0, 8'd0, 4'b0000, 0, 0, 2'd0));
    // Re-enable: warm-up again
    cyc(1, 1, 0, 4'b0000, 8'd9, 4'b0000, mk(2'd1, 8'd0, 4'b0000, 0, 0, 2'd0));
    cyc(1, 1, 0, 4'b0000, 8'd9, 4'b0000, mk(2'd1, 8'd0, 4'b0000, 0, 0, 2'd0));
    cyc(1, 1, 0, 4'b0000, 8'd9, 4'b0000, mk(2'd2, 8'd0, 4'b0000, 0, 0, 2'd0));
    cyc(1, 1, 0, 4'b0000, 8'd9, 4'b0001, mk(2'd2, 8'd1, 4'b0001, 0, 1, 2'd0));
    // Asynchronous reset mid-cycle
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_count",  32'(fault_count_o),  32'd0);
    check("async_rst_sticky", 32'(fault_sticky_o), 32'd0);
    check("async_rst_state",  32'(state_o),        32'd0);
    cyc(0, 1, 0, 4'b0000, 8'd9, 4'b0001, mk(2'd0, 8'd0, 4'b0000, 0, 0, 2'd0));
    cyc(1, 1, 0, 4'b0000, 8'd9, 4'b0000, mk(2'd1, 8'd0, 4'b0000, 0, 0, 2'd0));

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk_i);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
